// File: rtl/mul_combine.sv
// Folds three 16x16 partial products into the low 32 bits of a 32x32 product, carrying a tag alongside.
// Latency 1 cycle by default, 2 with MUL_COMBINE_PIPE2_EN (adds a stage for the mid-term add).
// Backpressure: valid/ready; a stage advances when its downstream is empty or transferring, and holds its output while stalled.
module mul_combine #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_p1,
   input  logic [31:0]      in_p2,
   input  logic [31:0]      in_p3,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // Only the low halves of p2/p3 reach bits below 32; their upper halves are dropped.
   logic [15:0] mid_sum;
   logic        unused_hi;
   assign mid_sum   = in_p2[15:0] + in_p3[15:0];
   assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

`ifdef MUL_COMBINE_PIPE2_EN
   logic             a_valid;
   logic [31:0]      a_p1;
   logic [15:0]      a_mid;
   logic [TAG_W-1:0] a_tag;
   logic             b_adv;

   assign b_adv    = !out_valid || out_ready;
   assign in_ready = !a_valid || b_adv;
   assign busy     = a_valid | out_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_valid    <= 1'b0;
         a_p1       <= '0;
         a_mid      <= '0;
         a_tag      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
               a_p1  <= in_p1;
               a_mid <= mid_sum;
               a_tag <= in_tag;
            end
         end
         if (b_adv) begin
            out_valid <= a_valid;
            if (a_valid) begin
               out_result <= a_p1 + {a_mid, 16'h0000};
               out_tag    <= a_tag;
            end
         end
      end
   end
`else
   assign in_ready = !out_valid || out_ready;
   assign busy     = out_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_result <= in_p1 + {mid_sum, 16'h0000};
            out_tag    <= in_tag;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mul_combine.sv
// Scoreboarded bench for mul_combine: directed corner cases plus randomized traffic against an arithmetic model.
module tb_mul_combine;
`ifdef MUL_COMBINE_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_p1, in_p2, in_p3;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   logic        held = 1'b0;
   logic [31:0] held_res;
   logic [4:0]  held_tag;

   mul_combine #(.TAG_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   // Full-width product arithmetic, truncated only at the end.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      logic [63:0] s;
      s = 64'(a) + ((64'(b & 32'h0000FFFF) + 64'(c & 32'h0000FFFF)) << 16);
      return s[31:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the item until the DUT takes it; waits = stall cycles seen.
   task automatic send(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                       input logic [4:0] tag, output int waits);
      logic acc;
      acc = 1'b0;
      waits = 0;
      in_valid = 1'b1;
      in_p1 = p1; in_p2 = p2; in_p3 = p3; in_tag = tag;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         acc = in_ready;
         step();
         if (acc) break;
         waits++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout tag=%0d actual=not_accepted required=accepted", tag);
      end
      in_valid = 1'b0;
   endtask

   // Monitor: pushes expectations on input handshakes, pops and compares on output handshakes.
   always @(negedge clk) begin
      if (reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, held_res);
            chk("hold_tag", 32'(out_tag), 32'(held_tag));
         end
         held = out_valid && !out_ready;
         held_res = out_result;
         held_tag = out_tag;
         if (in_valid && in_ready) begin
            exp_t e;
            e.res = model(in_p1, in_p2, in_p3);
            e.tag = in_tag;
            sb.push_back(e);
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output actual=tag%0d/%h required=none", out_tag, out_result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_result", out_result, e.res);
               chk("sb_tag", 32'(out_tag), 32'(e.tag));
            end
         end
      end
   end

   initial begin
      int w, a0, p0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) step();
      reset = 1'b0;

      // Basic product and latency
      send(32'h6, 32'h4, 32'h3, 5'd5, w);
      chk("first_accept_waits", 32'(w), 32'd0);
      repeat (LAT - 1) step();
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_result", out_result, 32'h00070006);
      chk("basic_tag", 32'(out_tag), 32'd5);
      step();

      // Wrap-around, including the discarded mid carry
      send(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd1, w);
      repeat (LAT - 1) step();
      chk("wrap_square", out_result, 32'h00000001);
      step();
      send(32'h0, 32'hFFFF8000, 32'hFFFF8000, 5'd2, w);
      repeat (LAT - 1) step();
      chk("wrap_midcarry", out_result, 32'h00000000);
      repeat (3) step();

      // Backpressure: only LAT entries fit, then release and drain in order
      out_ready = 1'b0;
      a0 = acc_cnt;
      fork
         begin
            for (int t = 1; t <= 4; t++) send($urandom, $urandom, $urandom, 5'(t), w);
         end
         begin
            repeat (6) step();
            chk("bp_accepted", 32'(acc_cnt - a0), 32'(LAT));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_head_tag", 32'(out_tag), 32'd1);
            out_ready = 1'b1;
         end
      join
      repeat (LAT + 2) step();
      chk("bp_drained", 32'(sb.size()), 32'd0);
      chk("bp_all_out", 32'(acc_cnt - a0), 32'd4);

      // Streaming: 8 back-to-back, no stalls, busy throughout
      p0 = pop_cnt;
      for (int i = 0; i < 8; i++) begin
         send($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), w);
         chk("stream_no_stall", 32'(w), 32'd0);
         chk("stream_busy", 32'(busy), 32'd1);
      end
      for (int i = 0; i < LAT; i++) begin
         chk("stream_busy_tail", 32'(busy), 32'd1);
         step();
      end
      chk("stream_idle", 32'(busy), 32'd0);
      chk("stream_pops", 32'(pop_cnt - p0), 32'd8);

      // Simultaneous in/out transfer loads the new entry with no bubble
      send(32'h11111111, 32'h2, 32'h3, 5'd9, w);
      send(32'h00001234, 32'h00010001, 32'h00020002, 5'd10, w);
      repeat (LAT - 1) step();
      chk("simul_valid", 32'(out_valid), 32'd1);
      chk("simul_result", out_result, 32'h00031234);
      chk("simul_tag", 32'(out_tag), 32'd10);
      repeat (3) step();

      // Reset while entries are in flight
      out_ready = 1'b0;
      send($urandom, $urandom, $urandom, 5'd20, w);
      if (LAT == 2) send($urandom, $urandom, $urandom, 5'd21, w);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_result", out_result, 32'd0);
      chk("mid_rst_tag", 32'(out_tag), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
      send(32'h5, 32'h0, 32'h1, 5'd3, w);
      chk("post_rst_accept", 32'(w), 32'd0);
      repeat (LAT + 2) step();

      // Randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 3) == 0) step();
               send($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), w);
            end
         end
         begin
            for (int i = 0; i < 400; i++) begin
               out_ready = ($urandom_range(0, 2) != 0);
               step();
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      repeat (LAT + 4) step();
      chk("final_drain", 32'(sb.size()), 32'd0);
      chk("final_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
